// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2,
        ERROR    = 2'd3
    } state_e;

    localparam logic [31:0] NOP       = 32'b0;
    localparam int          REG_IDX_W = 5;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use detector: the load in EX writes a register the instruction in ID reads.
module hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic                 mem_read_i,
    input  logic [REG_IDX_W-1:0] ex_rt_i,
    input  logic [REG_IDX_W-1:0] id_rs_i,
    input  logic [REG_IDX_W-1:0] id_rt_i,
    output logic                 load_use_o
);

    // r0 is hardwired to zero, so a load targeting it never creates a dependency
    assign load_use_o = mem_read_i && (ex_rt_i != '0) &&
                        ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory freeze, load-use stall,
// branch flush, start gating and sticky memory-timeout error.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 IDEX_MemRead_i,
    input  logic [REG_IDX_W-1:0] IDEX_RegRt_i,
    input  logic [REG_IDX_W-1:0] IFID_RegRs_i,
    input  logic [REG_IDX_W-1:0] IFID_RegRt_i,
    input  logic                 Branch_taken_i,
    input  logic                 EXMEM_MemAccess_i,
    input  logic                 dmem_ack_i,
    output logic                 dmem_req_o,
    output logic                 PC_write_o,
    output logic                 IFID_write_o,
    output logic                 IDEX_write_o,
    output logic                 EXMEM_write_o,
    output logic                 MEMWB_write_o,
    output logic                 IFID_flush_o,
    output logic                 IDEX_bubble_o,
    output logic                 MEMWB_bubble_o,
    output logic                 error_o,
    output logic [CNT_W-1:0]     stall_cnt_o
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d, wait_inc;
    logic                error_q, error_d;
    logic [CNT_W-1:0]    stall_q, stall_d;
    logic                load_use;
    logic                mem_pending;

    hazard_detect u_hazard_detect (
        .mem_read_i (IDEX_MemRead_i),
        .ex_rt_i    (IDEX_RegRt_i),
        .id_rs_i    (IFID_RegRs_i),
        .id_rt_i    (IFID_RegRt_i),
        .load_use_o (load_use)
    );

    assign wait_inc = wait_q + WAIT_W'(1);

    always_comb begin
        state_d        = state_q;
        wait_d         = wait_q;
        error_d        = error_q;
        stall_d        = stall_q;
        mem_pending    = 1'b0;
        dmem_req_o     = 1'b0;
        PC_write_o     = 1'b0;
        IFID_write_o   = 1'b0;
        IDEX_write_o   = 1'b0;
        EXMEM_write_o  = 1'b0;
        MEMWB_write_o  = 1'b0;
        IFID_flush_o   = 1'b0;
        IDEX_bubble_o  = 1'b0;
        MEMWB_bubble_o = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                end
            end
            RUN, MEM_WAIT: begin
                // Once in MEM_WAIT the request is held regardless of the EX/MEM view
                mem_pending = (state_q == MEM_WAIT) || EXMEM_MemAccess_i;
                dmem_req_o  = mem_pending;
                if (mem_pending && !dmem_ack_i) begin
                    MEMWB_write_o  = 1'b1;
                    MEMWB_bubble_o = 1'b1;
                    if (state_q == RUN) begin
                        state_d = MEM_WAIT;
                        wait_d  = '0;
                    end else if (wait_inc == WAIT_W'(TIMEOUT)) begin
                        state_d = ERROR;
                        error_d = 1'b1;
                    end else begin
                        wait_d = wait_inc;
                    end
                end else begin
                    state_d       = RUN;
                    PC_write_o    = 1'b1;
                    IFID_write_o  = 1'b1;
                    IDEX_write_o  = 1'b1;
                    EXMEM_write_o = 1'b1;
                    MEMWB_write_o = 1'b1;
                    // The branch in ID re-resolves after the stall, so no flush here
                    if (load_use) begin
                        PC_write_o    = 1'b0;
                        IFID_write_o  = 1'b0;
                        IDEX_bubble_o = 1'b1;
                    end else if (Branch_taken_i) begin
                        IFID_flush_o = 1'b1;
                    end
                end
                if (!PC_write_o && (stall_q != {CNT_W{1'b1}})) begin
                    stall_d = stall_q + CNT_W'(1);
                end
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            wait_q  <= '0;
            error_q <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            error_q <= error_d;
            stall_q <= stall_d;
        end
    end

    assign error_o     = error_q;
    assign stall_cnt_o = stall_q;

endmodule
